// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the memory stage.
// A request handshake is accepted in IDLE and its fields are captured. The
// access is performed after LATENCY wait cycles, and the response is held in
// RESP until the memory stage consumes it.
// The memory is a byte array with 8-byte little-endian accesses.
// Optional feature macro: DMEM_ALIGN_CHECK_EN makes any address with
// addr[2:0] != 0 an address error.
module dmem_responder #(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [63:0] resp_rdata_o,
    output logic        resp_error_o,
    output logic        busy_o
);

    localparam int          AW      = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [63:0] LAST_OK = 64'(MEM_BYTES - 8);
    localparam logic [3:0]  LAT     = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q;
    logic [63:0] addr_q, wdata_q;
    logic [63:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic        accept_s, access_s;
    logic        acc_write_s, err_s;
    logic [63:0] acc_addr_s, acc_wdata_s, rd_s;

    // Byte storage; it is not touched by reset and powers up as all zero.
    logic [7:0]  mem_q [MEM_BYTES] = '{default: 8'h00};

    // Select the fields of the access: the live inputs when the access happens
    // on the accept edge (LATENCY = 0), otherwise the captured request.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_write_s = req_write_i;
            acc_addr_s  = req_addr_i;
            acc_wdata_s = req_wdata_i;
        end else begin
            acc_write_s = write_q;
            acc_addr_s  = addr_q;
            acc_wdata_s = wdata_q;
        end
    end

    // Address error detection uses a full 64-bit compare, so it never wraps.
    always_comb begin
`ifdef DMEM_ALIGN_CHECK_EN
        err_s = (acc_addr_s > LAST_OK) || (acc_addr_s[2:0] != 3'b000);
`else
        err_s = (acc_addr_s > LAST_OK);
`endif
    end

    // Little-endian gather of 8 bytes that start at the access address.
    always_comb begin
        rd_s = 64'd0;
        for (int i = 0; i < 8; i++) begin
            rd_s[8*i +: 8] = mem_q[acc_addr_s[AW-1:0] + AW'(i)];
        end
    end

    // Next-state, counter and response logic. Reset overrides every input.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        accept_s = 1'b0;
        access_s = 1'b0;
        if (rst_i) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            rdata_d = 64'd0;
            error_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        accept_s = 1'b1;
                        if (LAT == 4'd0) begin
                            access_s = 1'b1;
                            state_d  = S_RESP;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = LAT;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        access_s = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RESP;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
            if (access_s) begin
                error_d = err_s;
                rdata_d = (err_s || acc_write_s) ? 64'd0 : rd_s;
            end else begin
                error_d = error_q;
            end
        end
    end

    // State, counter and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 64'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Capture the request on accept, so later input changes are ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            write_q <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
        end else if (accept_s) begin
            write_q <= req_write_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
        end else begin
            write_q <= write_q;
        end
    end

    // Store path: 8 bytes are written only for an error-free write access.
    always_ff @(posedge clk_i) begin
        if (access_s && acc_write_s && !err_s) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[acc_addr_s[AW-1:0] + AW'(i)] <= acc_wdata_s[8*i +: 8];
            end
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = (state_q == S_RESP);
    assign busy_o       = (state_q != S_IDLE);
    assign resp_rdata_o = rdata_q;
    assign resp_error_o = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder with default parameters (1024 bytes, LATENCY 2).
// It applies a vector table and then runs hand-written sequences for the
// response hold and reset-in-flight corner cases.
module tb_dmem_responder;

    localparam int LATENCY = 2;
    localparam int EXP_LAT = (LATENCY == 0) ? 0 : LATENCY + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic        busy;

    int errors = 0;
    int checks = 0;

    dmem_responder #(.MEM_BYTES(1024), .LATENCY(LATENCY)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_error_o (resp_error),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request. Returns at #1 after the edge on which resp_valid first rises.
    // If consume is 1, the response is also consumed (resp_ready must be 1).
    task automatic run_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                           input logic consume, output logic [63:0] rd,
                           output logic er, output int lat);
        int guard = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = ~a;
        req_wdata = ~d;
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 40) begin
            errors++;
            checks++;
            $display("FAIL timeout: got no response expected resp_valid for addr %h", a);
        end
        rd = resp_rdata;
        er = resp_error;
        if (consume) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [63:0] rd;
        logic [63:0] exp_10;
        logic        er;
        int          lat;

        vecs[0]  = '{1'b1, 64'h10, 64'h0123456789ABCDEF, 64'h0, 1'b0};
        vecs[1]  = '{1'b0, 64'h10, 64'h0, 64'h0123456789ABCDEF, 1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
        vecs[2]  = '{1'b0, 64'h11, 64'h0, 64'h0, 1'b1};
`else
        vecs[2]  = '{1'b0, 64'h11, 64'h0, 64'h000123456789ABCD, 1'b0};
`endif
        vecs[3]  = '{1'b0, 64'h3F9, 64'h0, 64'h0, 1'b1};
        vecs[4]  = '{1'b0, 64'h3F8, 64'h0, 64'h0, 1'b0};
        vecs[5]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 1'b1};
        vecs[6]  = '{1'b1, 64'h3F8, 64'h1122334455667788, 64'h0, 1'b0};
        vecs[7]  = '{1'b0, 64'h3F8, 64'h0, 64'h1122334455667788, 1'b0};
        vecs[8]  = '{1'b1, 64'h3FC, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b1};
        vecs[9]  = '{1'b0, 64'h3F8, 64'h0, 64'h1122334455667788, 1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
        vecs[10] = '{1'b1, 64'h14, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1};
        vecs[11] = '{1'b0, 64'h10, 64'h0, 64'h0123456789ABCDEF, 1'b0};
        vecs[12] = '{1'b0, 64'h18, 64'h0, 64'h0, 1'b0};
        exp_10   = 64'h0123456789ABCDEF;
`else
        vecs[10] = '{1'b1, 64'h14, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0};
        vecs[11] = '{1'b0, 64'h10, 64'h0, 64'hFFFFFFFF89ABCDEF, 1'b0};
        vecs[12] = '{1'b0, 64'h18, 64'h0, 64'h00000000FFFFFFFF, 1'b0};
        exp_10   = 64'hFFFFFFFF89ABCDEF;
`endif
        vecs[13] = '{1'b1, 64'h20, 64'h5555666677778888, 64'h0, 1'b0};
        vecs[14] = '{1'b0, 64'h20, 64'h0, 64'h5555666677778888, 1'b0};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset req_ready", 64'(req_ready), 64'd1);
        check("reset resp_valid", 64'(resp_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset rdata", resp_rdata, 64'd0);
        check("reset error", 64'(resp_error), 64'd0);

        for (int i = 0; i < 15; i++) begin
            run_req(vecs[i].write, vecs[i].addr, vecs[i].wdata, 1'b1, rd, er, lat);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d error", i), 64'(er), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(EXP_LAT));
        end

        // Response held while the consumer stalls.
        resp_ready = 1'b0;
        run_req(1'b0, 64'h10, 64'h0, 1'b0, rd, er, lat);
        check("hold first rdata", rd, exp_10);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d valid", c), 64'(resp_valid), 64'd1);
            check($sformatf("hold%0d rdata", c), resp_rdata, exp_10);
            check($sformatf("hold%0d error", c), 64'(resp_error), 64'd0);
            check($sformatf("hold%0d req_ready", c), 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("consume req_ready", 64'(req_ready), 64'd1);
        check("consume valid", 64'(resp_valid), 64'd0);
        check("consume busy", 64'(busy), 64'd0);

        // Reset during WAIT of a store discards the store.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h20;
        req_wdata = 64'hAAAAAAAAAAAAAAAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("wait busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst req_ready", 64'(req_ready), 64'd1);
        check("rst valid", 64'(resp_valid), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst rdata", resp_rdata, 64'd0);
        check("rst error", 64'(resp_error), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check("rst stays idle", 64'(resp_valid), 64'd0);
        run_req(1'b0, 64'h20, 64'h0, 1'b1, rd, er, lat);
        check("after rst rdata", rd, 64'h5555666677778888);
        check("after rst error", 64'(er), 64'd0);
        check("after rst latency", 64'(lat), 64'(EXP_LAT));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
